// File: rtl/sha256_block_core.sv
// SHA-256 compression core: loads one 512-bit block as 16 words, runs 64 rounds
// UNROLL per clock with an on-the-fly message schedule, and accumulates the chaining value.

module sha256_k (
  input  logic [5:0]  idx,
  output logic [31:0] k
);
  localparam logic [0:63][31:0] K_TAB = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  assign k = K_TAB[idx];
endmodule

// Handshakes: a word moves when in_valid && in_ready at a rising edge; the digest
// moves when out_valid && out_ready. Valid is held until accepted; ready never waits on valid.
module sha256_block_core #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_word,
  input  logic         in_first,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest,
  output logic [1:0]   dbg_state
);
  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
    $error("sha256_block_core: UNROLL must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {S_LOAD, S_ROUND, S_FINAL, S_OUT} state_t;

  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  state_t            state, state_nx;
  logic [3:0]        word_cnt;
  logic [6:0]        round_cnt;
  logic              first_q;
  logic [0:15][31:0] win;
  logic [0:7][31:0]  wk;
  logic [0:7][31:0]  hv;

  logic [0:15][31:0] rwin;
  logic [0:7][31:0]  rwk;
  logic [0:7][31:0]  h_sum;
  logic [31:0]       t1, t2, nw;
  logic [31:0]       k_r  [UNROLL];
  logic [5:0]        k_idx [UNROLL];

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  for (genvar u = 0; u < UNROLL; u++) begin : g_k
    assign k_idx[u] = round_cnt[5:0] + 6'(u);
    sha256_k u_k (.idx(k_idx[u]), .k(k_r[u]));
  end

  // Window slot 0 always holds W[t]; each round appends W[t+16] so the schedule
  // needs no special case below t=16.
  always_comb begin
    rwin = win;
    rwk  = wk;
    t1   = '0;
    t2   = '0;
    nw   = '0;
    for (int u = 0; u < UNROLL; u++) begin
      t1   = rwk[7] + bsig1(rwk[4]) + ((rwk[4] & rwk[5]) ^ (~rwk[4] & rwk[6])) + k_r[u] + rwin[0];
      t2   = bsig0(rwk[0]) + ((rwk[0] & rwk[1]) ^ (rwk[0] & rwk[2]) ^ (rwk[1] & rwk[2]));
      nw   = ssig1(rwin[14]) + rwin[9] + ssig0(rwin[1]) + rwin[0];
      rwk  = {t1 + t2, rwk[0], rwk[1], rwk[2], rwk[3] + t1, rwk[4], rwk[5], rwk[6]};
      rwin = {rwin[1:15], nw};
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      h_sum[i] = (first_q ? IV[i] : hv[i]) + wk[i];
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && word_cnt == 4'd15) state_nx = S_ROUND;
      end
      S_ROUND: if (round_cnt == 7'(64 - UNROLL)) state_nx = S_FINAL;
      S_FINAL: state_nx = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_LOAD;
      end
      default: state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_LOAD;
      word_cnt  <= '0;
      round_cnt <= '0;
      first_q   <= 1'b0;
      win       <= '0;
      wk        <= '0;
      hv        <= IV;
    end else if (clear) begin
      state     <= S_LOAD;
      word_cnt  <= '0;
      round_cnt <= '0;
      hv        <= IV;
    end else begin
      state <= state_nx;
      case (state)
        S_LOAD: if (in_valid) begin
          win      <= {win[1:15], in_word};
          word_cnt <= word_cnt + 4'd1;
          if (word_cnt == 4'd0) first_q <= in_first;
          if (word_cnt == 4'd15) begin
            wk        <= first_q ? IV : hv;
            round_cnt <= '0;
          end
        end
        S_ROUND: begin
          win       <= rwin;
          wk        <= rwk;
          round_cnt <= round_cnt + 7'(UNROLL);
        end
        S_FINAL: hv <= h_sum;
        default: ;
      endcase
    end
  end

  assign digest    = hv;
  assign dbg_state = state;
endmodule

// File: doc/sha256_block_core.md
# sha256_block_core

Parametrised SHA-256 compression core. Accepts one 512-bit message block as 16 big-endian 32-bit words over a valid/ready stream and runs the on-the-fly message schedule and 64 compression rounds, `UNROLL` rounds per clock. It adds the working variables into the chaining value and presents the 256-bit digest on a valid/ready output. It succeeds the single-round `Generator`, reuses the `K` and `InitialConstant` tables, and supports multi-block messages through chaining.

## Interface
- `UNROLL`, 1: rounds per clock; legal values are 1, 2, 4; any other value is an elaboration error.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous abort; overrides all other inputs.
- `in_valid` input 1: `in_word` is valid.
- `in_ready` output 1: core accepts a word this cycle.
- `in_word` input 32: message word W[i], i=0..15 in order.
- `in_first` input 1: sampled with word 0 only; 1 means chain from the IV, 0 means chain from the previous digest.
- `out_valid` output 1: `digest` holds a finished block result.
- `out_ready` input 1: consumer takes the digest.
- `digest` output 256: H0..H7, with H0 in bits [255:224].

## Operation
- States: LOAD, ROUND, FINAL, OUT.
- LOAD:
  - `in_ready`=1.
  - Each cycle with `in_valid`=1 shifts `in_word` into a 16-word window and increments the 4-bit word counter.
  - `in_first` is captured at word 0. On later words it is ignored.
  - When word 15 is accepted, the next state is ROUND. The working variables a..h load from the IV (first=1) or from H (first=0), and the round counter is cleared.
- ROUND:
  - `in_ready`=0.
  - Each cycle performs rounds t..t+UNROLL-1, then t += UNROLL.
  - W[t] for t<16 comes from the window. For t≥16, W[t]=σ1(W[t-2])+W[t-7]+σ0(W[t-15])+W[t-16] mod 2^32, and the window shifts by one per round.
  - K[t] comes from UNROLL instances of `K`.
  - After t reaches 64, the next state is FINAL.
- FINAL:
  - H_i ← H_i + working_i mod 2^32 for all i; H is also loaded with the IV first when first=1.
  - Next state is OUT.
- OUT:
  - `out_valid`=1 and `digest`=H.
  - When `out_ready`=1, the next state is LOAD.
  - H is retained so that the next block with `in_first`=0 chains from it.
- All additions are 32-bit, mod 2^32, with carries discarded. Carry-save compressors are allowed internally, but the result must be bit-exact.
- `clear`=1: next state is LOAD, the word counter is 0, H ← IV, and `out_valid` drops the next cycle. Any block in flight is discarded.
- `rst_n`=0, asynchronous:
  - state LOAD, `in_ready`=1, `out_valid`=0;
  - H=IV (6a09e667…5be0cd19), so `digest` reads the IV;
  - counters 0, window 0.
- Reset asserted mid-ROUND takes effect immediately; no partial digest is ever presented.
- `in_valid` while not in LOAD is ignored; no word is consumed.

## Timing
- Word acceptance: on the edge where `in_valid` && `in_ready`.
- Minimum load time: 16 cycles.
- 16th word accepted at edge T:
  - ROUND occupies edges T+1 … T+64/UNROLL;
  - FINAL is edge T+64/UNROLL+1;
  - `out_valid`=1 from the cycle after that edge.
- Latency from the last word to `out_valid`:
  - UNROLL=1: 66 cycles;
  - UNROLL=2: 34 cycles;
  - UNROLL=4: 18 cycles.
- `out_valid` stays high and `digest` stays stable until `out_ready`. In the handshake cycle (`out_valid`=1 and `out_ready`=1), `in_ready` is still 0. `in_ready`=1 from the next cycle.
- Throughput for back-to-back blocks: 16 + 64/UNROLL + 2 cycles per block with `out_ready` tied high.
- `digest` changes only at the FINAL edge, on `clear`, or on reset.

## Test plan
- **"abc"**: W0=61626380, W1..W14=0, W15=00000018, `in_first`=1, UNROLL=1.
  - Required: `digest`=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
  - Required: `out_valid` exactly 66 cycles after the last word.
- **Empty message**: W0=80000000, rest 0, `in_first`=1, run for UNROLL=2 and UNROLL=4.
  - Required: `digest`=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
  - Required: latency 34 cycles (UNROLL=2) and 18 cycles (UNROLL=4).
- **Two-block chaining**: message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"; block 1 with `in_first`=1, block 2 with `in_first`=0.
  - Required: final `digest`=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
  - Required: `in_first` toggled on words 1..15 has no effect.
- **Backpressure**: random `in_valid` gaps during load; hold `out_ready`=0 for 20 cycles.
  - Required: the "abc" digest is unchanged and `out_valid` is held high.
  - Required: `in_ready`=0 throughout ROUND, FINAL and OUT.
  - Required: `in_valid` pulses during ROUND are not consumed.
- **Abort**: pulse `clear` at round 30, then send an "abc" block with `in_first`=0.
  - Required: the "abc" digest is produced, proving H was reset to the IV.
- **Reset**: assert `rst_n`=0 asynchronously mid-ROUND.
  - Required immediately: `out_valid`=0, `in_ready`=1, `digest`=IV.
  - Required: the next "abc" block produces the correct digest.
